// File: rtl/cpu_exec_ctrl_pkg.sv
// Shared definitions for the CPU execution controller.
// Holds the state encodings (HALT=0, RUN=1, STEP=2, BREAK=3), which are
// visible on the state output, plus a helper that classifies stopped states.
package cpu_exec_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_HALT  = 2'd0,
        CTRL_RUN   = 2'd1,
        CTRL_STEP  = 2'd2,
        CTRL_BREAK = 2'd3
    } ctrl_state_e;

    // True for the states in which the CPU is not advancing.
    function automatic logic is_stopped(input ctrl_state_e s);
        return (s == CTRL_HALT) || (s == CTRL_BREAK);
    endfunction

endpackage

// File: rtl/cpu_exec_ctrl_rise_detect.sv
// Synchronous rising-edge detector, usable for any debounced button.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset
//   din     - level input, already synchronous to clk
//   pulse   - high while din is 1 and was 0 on the previous clk
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Run/halt/single-step sequencer. Produces one-clk enable pulses on the
// board clock: ram_ce mid CPU cycle and cpu_ce at the end of each cycle.
// Ports:
//   clk, reset_n        - board clock, asynchronous active-low reset
//   run_sw              - free-run request level
//   step_btn            - debounced step button (rising edge = step event)
//   halt_req            - halt request level from the CPU
//   bp_en, bp_adrs, pc  - PC breakpoint enable/address and current PC
//   cpu_ce, ram_ce      - registered one-clk enables
//   state               - current controller state
//   halted              - 1 in HALT or BREAK
//   cycle_cnt           - number of cpu_ce pulses issued (wraps)
module cpu_exec_ctrl
    import cpu_exec_ctrl_pkg::*;
#(
    parameter int unsigned DIV   = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_adrs,
    input  logic [31:0]      pc,
    output logic             cpu_ce,
    output logic             ram_ce,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned     PH_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(DIV / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

    ctrl_state_e      state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             ram_ce_q, ram_ce_d;
    logic             halted_q, halted_d;
    logic             bp_skip_q, bp_skip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_evt;
    logic             bp_hit;

    rise_detect u_step_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (step_btn),
        .pulse   (step_evt)
    );

    // bp_skip masks the breakpoint until one instruction has run after
    // leaving HALT, so resuming at pc==bp_adrs makes progress.
    assign bp_hit = bp_en && (pc == bp_adrs) && !bp_skip_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bp_skip_d = bp_skip_q;
        ram_ce_d  = 1'b0;
        cpu_ce_d  = 1'b0;
        unique case (state_q)
            CTRL_HALT: begin
                phase_d = '0;
                if (step_evt) begin
                    state_d   = CTRL_STEP;
                    bp_skip_d = 1'b1;
                end else if (run_sw && !halt_req) begin
                    state_d   = CTRL_RUN;
                    bp_skip_d = 1'b1;
                end
            end
            CTRL_BREAK: begin
                phase_d = '0;
                if (step_evt) begin
                    state_d = CTRL_STEP;
                end else if (!run_sw) begin
                    state_d = CTRL_HALT;
                end
            end
            CTRL_RUN, CTRL_STEP: begin
                ram_ce_d = (phase_q == PH_MID);
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    // A breakpoint hit outranks run_sw=0 and halt_req.
                    if (state_q == CTRL_RUN && bp_hit) begin
                        state_d = CTRL_BREAK;
                    end else begin
                        cpu_ce_d = 1'b1;
                        if (state_q == CTRL_RUN) begin
                            bp_skip_d = 1'b0;
                            if (!run_sw || halt_req) begin
                                state_d = CTRL_HALT;
                            end
                        end else begin
                            state_d = CTRL_HALT;
                        end
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = CTRL_HALT;
                phase_d = '0;
            end
        endcase
        halted_d = is_stopped(state_d);
        cnt_d    = cnt_q + CNT_W'(cpu_ce_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CTRL_HALT;
            phase_q   <= '0;
            cpu_ce_q  <= 1'b0;
            ram_ce_q  <= 1'b0;
            halted_q  <= 1'b1;
            bp_skip_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cpu_ce_q  <= cpu_ce_d;
            ram_ce_q  <= ram_ce_d;
            halted_q  <= halted_d;
            bp_skip_q <= bp_skip_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign ram_ce    = ram_ce_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
module tb_cpu_exec_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run_sw, step_btn, halt_req, bp_en;
    logic [31:0] bp_adrs, pc;
    logic        cpu_ce, ram_ce, halted;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic        cpu_ce4, ram_ce4, halted4;
    logic [1:0]  state4;
    logic [3:0]  cycle_cnt4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_exec_ctrl #(.DIV(DIV), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .run_sw(run_sw), .step_btn(step_btn),
        .halt_req(halt_req), .bp_en(bp_en), .bp_adrs(bp_adrs), .pc(pc),
        .cpu_ce(cpu_ce), .ram_ce(ram_ce), .state(state), .halted(halted),
        .cycle_cnt(cycle_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, for the wrap check.
    cpu_exec_ctrl #(.DIV(DIV), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .run_sw(run_sw), .step_btn(step_btn),
        .halt_req(halt_req), .bp_en(bp_en), .bp_adrs(bp_adrs), .pc(pc),
        .cpu_ce(cpu_ce4), .ram_ce(ram_ce4), .state(state4), .halted(halted4),
        .cycle_cnt(cycle_cnt4)
    );

    // Reference model: mode 0=halt 1=run 2=step 3=break; pos = clk within cycle.
    int          m_mode, m_pos;
    bit          m_skip, m_prev;
    int unsigned m_cnt;
    bit          e_cpu, e_ram;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_skip = 0; m_prev = 0;
        m_cnt = 0; e_cpu = 0; e_ram = 0;
    endtask

    task automatic model_clock();
        bit stepped;
        stepped = step_btn && !m_prev;
        m_prev  = step_btn;
        e_cpu   = 0;
        e_ram   = 0;
        if (m_mode == 0 || m_mode == 3) begin
            m_pos = 0;
            if (stepped) begin
                if (m_mode == 0) m_skip = 1;
                m_mode = 2;
            end else if (m_mode == 0 && run_sw && !halt_req) begin
                m_skip = 1;
                m_mode = 1;
            end else if (m_mode == 3 && !run_sw) begin
                m_mode = 0;
            end
        end else begin
            if (m_pos == DIV / 2 - 1) e_ram = 1;
            if (m_pos == DIV - 1) begin
                m_pos = 0;
                if (m_mode == 1 && bp_en && pc == bp_adrs && !m_skip) begin
                    m_mode = 3;
                end else begin
                    e_cpu = 1;
                    m_cnt = m_cnt + 1;
                    if (m_mode == 2) m_mode = 0;
                    else begin
                        m_skip = 0;
                        if (!run_sw || halt_req) m_mode = 0;
                    end
                end
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_cnt32;
        logic [3:0]  e_cnt4;
        e_cnt32 = m_cnt;
        e_cnt4  = e_cnt32[3:0];
        check("state",      {30'b0, state},     m_mode);
        check("cpu_ce",     {31'b0, cpu_ce},    {31'b0, e_cpu});
        check("ram_ce",     {31'b0, ram_ce},    {31'b0, e_ram});
        check("halted",     {31'b0, halted},    (m_mode == 0 || m_mode == 3) ? 32'd1 : 32'd0);
        check("cycle_cnt",  cycle_cnt,          e_cnt32);
        check("cycle_cnt4", {28'b0, cycle_cnt4}, {28'b0, e_cnt4});
        check("state4",     {30'b0, state4},    m_mode);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_clock();
        @(negedge clk);
        compare_all();
        if (e_cpu) pc = pc + 32'd4;
    endtask

    task automatic wait_for(input int mode, input int pos, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_mode == mode && (pos < 0 || m_pos == pos)) begin
                hit = 1;
                break;
            end
            tick();
        end
        if (!hit) begin
            tests++;
            fails++;
            $error("FAIL %s: observed timeout expected mode %0d pos %0d", tag, mode, pos);
        end
    endtask

    initial begin
        reset_n = 0; run_sw = 0; step_btn = 0; halt_req = 0;
        bp_en = 0; bp_adrs = 32'h10; pc = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset_n = 1;

        // Idle in HALT.
        repeat (50) tick();

        // Free run, then drop run_sw mid-cycle.
        run_sw = 1;
        repeat (45) tick();
        wait_for(1, 1, "run_mid");
        run_sw = 0;
        repeat (8) tick();

        // Single steps with the button held.
        for (int n = 0; n < 2; n++) begin
            step_btn = 1;
            repeat (7) tick();
            step_btn = 0;
            repeat (4) tick();
        end

        // Breakpoint, then resume via HALT without re-breaking.
        pc = 32'h08; bp_en = 1; run_sw = 1;
        wait_for(3, -1, "bp_reach1");
        repeat (6) tick();
        run_sw = 0;
        repeat (2) tick();
        run_sw = 1;
        repeat (12) tick();
        run_sw = 0;
        repeat (6) tick();

        // Breakpoint, then step out of BREAK.
        pc = 32'h0C; run_sw = 1;
        wait_for(3, -1, "bp_reach2");
        repeat (3) tick();
        step_btn = 1;
        repeat (7) tick();
        step_btn = 0;
        run_sw = 0;
        repeat (8) tick();
        bp_en = 0;

        // halt_req mid-cycle, and blocking RUN entry while held.
        run_sw = 1;
        wait_for(1, 1, "hreq_mid");
        halt_req = 1;
        repeat (12) tick();
        halt_req = 0;
        repeat (6) tick();
        run_sw = 0;
        repeat (6) tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 29) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 7) == 0) pc = 32'h08 + 32'd4 * $urandom_range(0, 3);
            tick();
        end

        // Asynchronous reset in RUN at phase 2.
        run_sw = 0; step_btn = 0; halt_req = 0; bp_en = 0;
        repeat (8) tick();
        run_sw = 1;
        wait_for(1, 2, "rst_phase");
        #1 reset_n = 0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        reset_n = 1;
        run_sw = 0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_exec_ctrl.md
Name: cpu_exec_ctrl

Overview:
Run/halt/single-step sequencer for the CPU core. It replaces free-running prescaled clocks with single-cycle enable pulses on the board clock: cpu_ce advances the CPU and ram_ce strobes the RAM mid-cycle. It supports a run switch, a debounced step button, a PC breakpoint and a CPU-requested halt. It sits between the top level (switches, button, LED mux) and the CPU.

Parameters:
DIV, 4, board clocks per CPU cycle; even, >= 2
CNT_W, 32, width of executed-cycle counter

Ports:
clk  in  1  board clock
reset_n  in  1  asynchronous active-low reset
run_sw  in  1  level; 1 = free run requested
step_btn  in  1  debounced step button level (active-high)
halt_req  in  1  level from CPU (halt instruction executed)
bp_en  in  1  breakpoint enable
bp_adrs  in  32  breakpoint PC
pc  in  32  current CPU PC (updates after each cpu_ce)
cpu_ce  out  1  one-clk pulse: CPU executes one cycle
ram_ce  out  1  one-clk pulse: RAM access strobe
state  out  2  current state, encoding from `defines.v`
halted  out  1  1 in HALT or BREAK
cycle_cnt  out  CNT_W  number of cpu_ce pulses issued

Behaviour:
- Reset (async, reset_n=0): state=HALT, phase=0, cpu_ce=0, ram_ce=0, halted=1, cycle_cnt=0, bp_skip=0, step edge register=0. All outputs are registered.
- Phase counter runs 0..DIV-1 only in RUN/STEP. It is forced to 0 in HALT/BREAK.
- ram_ce=1 in the clk after phase==DIV/2-1. cpu_ce=1 in the clk after phase==DIV-1, unless suppressed by a breakpoint.
- Step event: a rising edge of step_btn, detected synchronously. The event is consumed only in HALT/BREAK and ignored in RUN/STEP.
- HALT:
  - step event -> STEP.
  - else run_sw=1 and halt_req=0 -> RUN.
  - bp_skip is set on any exit.
- RUN, at phase DIV-1:
  - If bp_en, pc==bp_adrs and bp_skip=0: no cpu_ce; go to BREAK.
  - Otherwise issue cpu_ce and clear bp_skip. Then, if run_sw=0 or halt_req=1, go to HALT; else phase wraps to 0 and RUN continues.
  - run_sw falling mid-cycle does not truncate the cycle; ram_ce/cpu_ce still complete.
- STEP: exactly one full cycle (ram_ce, then cpu_ce). The breakpoint is ignored. Then go to HALT.
- BREAK:
  - step event -> STEP (executes the breakpointed instruction).
  - run_sw=0 -> HALT.
  - Otherwise hold. Re-entering RUN requires run_sw 1->0->1 via HALT.
- halt_req while in HALT blocks the RUN entry but not STEP.
- cycle_cnt increments by 1 on every cpu_ce and wraps modulo 2^CNT_W.
- Simultaneous events at phase DIV-1: a breakpoint hit has priority over run_sw=0 and halt_req; the resulting state is BREAK.
- Breakpoint re-arming: bp_skip guarantees that resuming from a PC equal to bp_adrs executes at least one instruction before the breakpoint can fire again.

Decomposition:
- `defines.v` gains state encodings: `CTRL_HALT 2'd0, `CTRL_RUN 2'd1, `CTRL_STEP 2'd2, `CTRL_BREAK 2'd3.
- Sub-module rise_detect (clk, reset_n, din, pulse) generates the step event; it is reusable for other buttons.
- FSM, phase counter and cycle counter stay in cpu_exec_ctrl.

Test Plan:
- Reset and idle: reset_n low then high, all inputs 0 -> state=0, halted=1, no cpu_ce/ram_ce for 50 clks, cycle_cnt=0.
- Free run, DIV=4: run_sw=1 -> ram_ce every 4 clks, cpu_ce every 4 clks lagging ram_ce by 2, cycle_cnt=10 after 10 cpu_ce. run_sw=0 mid-cycle -> that cycle completes, then HALT.
- Single step: in HALT, pulse step_btn for 7 clks -> exactly one ram_ce and one cpu_ce, cycle_cnt +1, back to HALT. Holding the button issues no second step.
- Breakpoint: bp_en=1, bp_adrs=0x10, pc stepped 0x08,0x0C,0x10 by the bench model -> BREAK with no cpu_ce at pc=0x10. A step then yields one cpu_ce with pc=0x10 executed. Toggling run_sw via HALT resumes RUN without re-breaking at 0x10.
- halt_req: assert during RUN at phase 1 -> cpu_ce still issued at the cycle end, then HALT. While halt_req stays 1 with run_sw=1, the state remains HALT.
- Async reset mid-RUN at phase 2 -> outputs clear immediately without waiting for a clk edge; cycle_cnt=0. Wrap check: preload CNT_W=4, 17 cpu_ce -> cycle_cnt=1.
